// File: rtl/stream_mem_writer_pkg.sv
// Shared definitions for the byte-stream to 32-bit memory writer.
package stream_mem_writer_pkg;

  localparam int LANES      = 4;
  localparam int BYTE_W     = 8;
  localparam int MEM_DATA_W = 32;
  localparam int LANE_IDX_W = $clog2(LANES);

  // Transfer sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/stream_mem_writer.sv
// Collects a byte stream into little-endian 32-bit words and writes each
// word (with per-lane byte enables) to an on-chip memory, one write per word.
module stream_mem_writer
  import stream_mem_writer_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [CNT_W-1:0]      byte_count,
  input  logic [BYTE_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [LANES-1:0]      mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [MEM_DATA_W-1:0] mem_writedata,
  output logic                  mem_clken,
  output logic                  busy,
  output logic                  done
);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [CNT_W-1:0]        remaining_q, remaining_d;
  logic [LANE_IDX_W-1:0]   lane_q, lane_d;
  logic [MEM_DATA_W-1:0]   word_q, word_d;
  logic [LANES-1:0]        byteEn_q, byteEn_d;
  logic                    memWrite_q, memWrite_d;
  logic                    accept;
  logic                    wordComplete;

  assign accept       = in_valid & in_ready;
  assign wordComplete = (lane_q == LANE_IDX_W'(LANES - 1)) ||
                        (remaining_q == CNT_W'(1));

  // State register; reset drops any transfer in flight back to IDLE
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a word is flushed after its last lane or the final byte
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (byte_count != '0) ? FILL : DONE;
        end
      end
      FILL: begin
        if (accept && wordComplete) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = (remaining_q != '0) ? FILL : DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake and status outputs decoded from the current state
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
      end
      FILL: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      WRITE: begin
        busy = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Datapath next values: latch the job, pack bytes, advance after a write
  always_comb begin
    addr_d      = addr_q;
    remaining_d = remaining_q;
    lane_d      = lane_q;
    word_d      = word_q;
    byteEn_d    = byteEn_q;
    unique case (state_q)
      IDLE: begin
        if (start && (byte_count != '0)) begin
          addr_d      = base_addr;
          remaining_d = byte_count;
          lane_d      = '0;
          word_d      = '0;
          byteEn_d    = '0;
        end
      end
      FILL: begin
        if (accept) begin
          word_d[lane_q*BYTE_W +: BYTE_W] = in_data;
          byteEn_d[lane_q]                = 1'b1;
          remaining_d                     = remaining_q - CNT_W'(1);
          lane_d                          = lane_q + LANE_IDX_W'(1);
        end
      end
      WRITE: begin
        addr_d   = addr_q + ADDR_W'(1);
        lane_d   = '0;
        word_d   = '0;
        byteEn_d = '0;
      end
      default: begin
      end
    endcase
    memWrite_d = (state_d == WRITE);
  end

  // Datapath registers; the memory port is driven straight from these flops
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q      <= '0;
      remaining_q <= '0;
      lane_q      <= '0;
      word_q      <= '0;
      byteEn_q    <= '0;
      memWrite_q  <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      lane_q      <= lane_d;
      word_q      <= word_d;
      byteEn_q    <= byteEn_d;
      memWrite_q  <= memWrite_d;
    end
  end

  assign mem_address    = addr_q;
  assign mem_byteenable = byteEn_q;
  assign mem_writedata  = word_q;
  assign mem_write      = memWrite_q;
  assign mem_chipselect = memWrite_q;
  assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_stream_mem_writer.sv
// Self-checking bench: table vectors, random transfers against a word-level
// model of the expected memory writes, and a mid-transfer reset sequence.
module tb_stream_mem_writer;

  localparam int ADDR_W = 14;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  byte_count;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_clken;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;

  logic [7:0]        byteBuf [0:63];
  logic [ADDR_W-1:0] expAddr [$];
  logic [31:0]       expData [$];
  logic [3:0]        expBe   [$];

  typedef struct {
    logic [ADDR_W-1:0] base;
    int                count;
    logic [7:0]        firstByte;
    int                gapMode;
    bit                midStart;
    int                expWrites;
    logic [ADDR_W-1:0] expLastAddr;
    logic [31:0]       expLastData;
    logic [3:0]        expLastBe;
  } vec_t;

  vec_t vecs [7];

  stream_mem_writer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .byte_count     (byte_count),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .busy           (busy),
    .done           (done)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Expected writes: consecutive 4-byte groups of the stream, little-endian
  task automatic buildModel(input logic [ADDR_W-1:0] base, input int count);
    int nWords;
    expAddr.delete();
    expData.delete();
    expBe.delete();
    nWords = (count + 3) / 4;
    for (int w = 0; w < nWords; w++) begin
      logic [31:0] wd;
      logic [3:0]  be;
      wd = '0;
      be = '0;
      for (int l = 0; l < 4; l++) begin
        if (w * 4 + l < count) begin
          wd = wd | (32'(byteBuf[w * 4 + l]) << (8 * l));
          be = be | (4'(1) << l);
        end
      end
      expAddr.push_back(ADDR_W'(int'(base) + w));
      expData.push_back(wd);
      expBe.push_back(be);
    end
  endtask

  task automatic applyStimulus(input logic [ADDR_W-1:0] base, input int count,
                               input int gapMode, input bit midStart,
                               output int nWrites, output logic [ADDR_W-1:0] lastAddr,
                               output logic [31:0] lastData, output logic [3:0] lastBe);
    int  idx, cyc, doneCyc, lastWriteCyc, budget;
    bit  doneSeen, v;
    buildModel(base, count);
    nWrites = 0;
    lastAddr = '0;
    lastData = '0;
    lastBe = '0;
    idx = 0;
    cyc = 0;
    doneSeen = 1'b0;
    doneCyc = -1;
    lastWriteCyc = -1;
    budget = 20 * count + 50;
    @(negedge clk);
    start      = 1'b1;
    base_addr  = base;
    byte_count = CNT_W'(count);
    in_valid   = 1'b0;
    while (!doneSeen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (mem_write) begin
        nWrites++;
        lastWriteCyc = cyc;
        lastAddr = mem_address;
        lastData = mem_writedata;
        lastBe = mem_byteenable;
        if (expAddr.size() == 0) begin
          checkOutput("unexpected write", 32'd1, 32'd0);
        end else begin
          checkOutput("write addr", 32'(mem_address), 32'(expAddr.pop_front()));
          checkOutput("write data", mem_writedata, expData.pop_front());
          checkOutput("write be", 32'(mem_byteenable), 32'(expBe.pop_front()));
        end
        checkOutput("chipselect", 32'(mem_chipselect), 32'd1);
        checkOutput("ready in write", 32'(in_ready), 32'd0);
      end else begin
        checkOutput("chipselect idle", 32'(mem_chipselect), 32'd0);
      end
      checkOutput("clken", 32'(mem_clken), 32'd1);
      if (done) begin
        doneSeen = 1'b1;
        doneCyc = cyc;
        checkOutput("busy at done", 32'(busy), 32'd0);
      end else begin
        checkOutput("busy", 32'(busy), (count != 0) ? 32'd1 : 32'd0);
      end
      if (midStart && cyc == 3) begin
        start      = 1'b1;
        base_addr  = 14'h2AAA;
        byte_count = 16'd3;
      end else begin
        start = 1'b0;
      end
      if (idx < count) begin
        if (gapMode == 0) v = 1'b1;
        else if (gapMode == 1) v = cyc[0];
        else v = 1'($urandom_range(0, 1));
        in_valid = v;
        in_data  = v ? byteBuf[idx] : 8'($urandom);
        if (v && in_ready) idx++;
      end else begin
        in_valid = 1'b0;
      end
    end
    if (!doneSeen) checkOutput("done timeout", 32'd0, 32'd1);
    checkOutput("writes pending", 32'(expAddr.size()), 32'd0);
    if (count == 0) checkOutput("zero-count done latency", 32'(doneCyc), 32'd1);
    else checkOutput("done after last write", 32'(doneCyc), 32'(lastWriteCyc + 1));
    checkOutput("bytes consumed", 32'(idx), 32'(count));
    start = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("done is a pulse", 32'(done), 32'd0);
    checkOutput("idle busy", 32'(busy), 32'd0);
    checkOutput("idle ready", 32'(in_ready), 32'd0);
    checkOutput("idle write", 32'(mem_write), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " ready"}, 32'(in_ready), 32'd0);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " done"}, 32'(done), 32'd0);
    checkOutput({tag, " write"}, 32'(mem_write), 32'd0);
    checkOutput({tag, " cs"}, 32'(mem_chipselect), 32'd0);
    checkOutput({tag, " addr"}, 32'(mem_address), 32'd0);
    checkOutput({tag, " be"}, 32'(mem_byteenable), 32'd0);
    checkOutput({tag, " data"}, mem_writedata, 32'd0);
    checkOutput({tag, " clken"}, 32'(mem_clken), 32'd1);
  endtask

  initial begin
    int                nW;
    logic [ADDR_W-1:0] la;
    logic [31:0]       ld;
    logic [3:0]        lb;

    // base, count, first byte, gap mode, mid start, writes, last addr/data/be
    vecs[0] = '{14'h0010, 8, 8'h01, 0, 1'b0, 2, 14'h0011, 32'h08070605, 4'hF};
    vecs[1] = '{14'h0020, 6, 8'hA0, 0, 1'b0, 2, 14'h0021, 32'h0000A5A4, 4'h3};
    vecs[2] = '{14'h3FFF, 8, 8'h11, 0, 1'b0, 2, 14'h0000, 32'h18171615, 4'hF};
    vecs[3] = '{14'h0100, 0, 8'h00, 0, 1'b0, 0, 14'h0000, 32'h00000000, 4'h0};
    vecs[4] = '{14'h0010, 8, 8'h01, 1, 1'b1, 2, 14'h0011, 32'h08070605, 4'hF};
    vecs[5] = '{14'h0040, 1, 8'h5A, 0, 1'b0, 1, 14'h0040, 32'h0000005A, 4'h1};
    vecs[6] = '{14'h0050, 5, 8'h30, 1, 1'b0, 2, 14'h0051, 32'h00000034, 4'h1};

    reset_n    = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    byte_count = '0;
    in_data    = '0;
    in_valid   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      for (int b = 0; b < 64; b++) byteBuf[b] = 8'(int'(vecs[i].firstByte) + b);
      applyStimulus(vecs[i].base, vecs[i].count, vecs[i].gapMode, vecs[i].midStart,
                    nW, la, ld, lb);
      checkOutput($sformatf("vec%0d writes", i), 32'(nW), 32'(vecs[i].expWrites));
      if (vecs[i].expWrites > 0) begin
        checkOutput($sformatf("vec%0d last addr", i), 32'(la), 32'(vecs[i].expLastAddr));
        checkOutput($sformatf("vec%0d last data", i), ld, vecs[i].expLastData);
        checkOutput($sformatf("vec%0d last be", i), 32'(lb), 32'(vecs[i].expLastBe));
      end
    end

    for (int r = 0; r < 8; r++) begin
      for (int b = 0; b < 64; b++) byteBuf[b] = 8'($urandom);
      applyStimulus(ADDR_W'($urandom), $urandom_range(1, 40), 2,
                    1'($urandom_range(0, 1)), nW, la, ld, lb);
    end

    // Reset after two of four bytes: partial word must never reach memory
    for (int b = 0; b < 4; b++) byteBuf[b] = 8'(8'hC0 + b);
    @(negedge clk);
    start      = 1'b1;
    base_addr  = 14'h0200;
    byte_count = 16'd4;
    @(negedge clk);
    start = 1'b0;
    checkOutput("rst seq ready", 32'(in_ready), 32'd1);
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      in_data  = byteBuf[b];
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("rst seq still filling", 32'(busy), 32'd1);
    reset_n = 1'b0;
    in_valid = 1'b1;
    in_data = byteBuf[2];
    @(negedge clk);
    checkResetOutputs("mid reset");
    reset_n = 1'b1;
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("post reset write", 32'(mem_write), 32'd0);
      checkOutput("post reset busy", 32'(busy), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
